// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename state (busy + ROB tag).
// Reads are combinational with a same-cycle commit bypass; x0 is hardwired zero.
module rename_regfile #(
    parameter int NUM_REGS      = 32,
    parameter int REG_ID_BIT    = 5,
    parameter int ROB_WIDTH_BIT = 4,
    parameter int XLEN          = 32,
    parameter int NUM_READ      = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              rdy_in,
    input  logic                              flush_in,
    input  logic                              rename_en,
    input  logic [REG_ID_BIT-1:0]             rename_reg,
    input  logic [ROB_WIDTH_BIT-1:0]          rename_tag,
    input  logic                              commit_en,
    input  logic [REG_ID_BIT-1:0]             commit_reg,
    input  logic [ROB_WIDTH_BIT-1:0]          commit_tag,
    input  logic [XLEN-1:0]                   commit_value,
    input  logic [NUM_READ*REG_ID_BIT-1:0]    rd_reg,
    output logic [NUM_READ-1:0]               rd_busy,
    output logic [NUM_READ*XLEN-1:0]          rd_value,
    output logic [NUM_READ*ROB_WIDTH_BIT-1:0] rd_tag,
    output logic [REG_ID_BIT:0]               busy_count
);

    logic [XLEN-1:0]          regs_q [NUM_REGS];
    logic [XLEN-1:0]          regs_d [NUM_REGS];
    logic [ROB_WIDTH_BIT-1:0] tag_q  [NUM_REGS];
    logic [ROB_WIDTH_BIT-1:0] tag_d  [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q, busy_d;
    logic [REG_ID_BIT:0]      busy_count_q, busy_count_d;
    logic                     commit_wr, rename_wr;

    assign commit_wr = commit_en && (commit_reg != '0);
    assign rename_wr = rename_en && (rename_reg != '0);

    // Commit is applied before rename so a same-register rename owns busy/tag;
    // flush then overrides all rename state but keeps the committed value.
    always_comb begin
        regs_d = regs_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (rdy_in) begin
            if (commit_wr) begin
                regs_d[commit_reg] = commit_value;
                if (tag_q[commit_reg] == commit_tag) begin
                    busy_d[commit_reg] = 1'b0;
                end
            end
            if (rename_wr) begin
                busy_d[rename_reg] = 1'b1;
                tag_d[rename_reg]  = rename_tag;
            end
            if (flush_in) begin
                busy_d = '0;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    tag_d[i] = '0;
                end
            end
        end
        busy_count_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            busy_count_d = busy_count_d + {{REG_ID_BIT{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else if (rdy_in) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
                tag_q[i]  <= tag_d[i];
            end
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    always_comb begin
        logic [REG_ID_BIT-1:0] idx;
        rd_busy  = '0;
        rd_value = '0;
        rd_tag   = '0;
        for (int unsigned p = 0; p < NUM_READ; p++) begin
            idx = rd_reg[p*REG_ID_BIT +: REG_ID_BIT];
            if (idx != '0) begin
                if (busy_q[idx] && commit_en && (commit_reg == idx) &&
                    (tag_q[idx] == commit_tag)) begin
                    rd_value[p*XLEN +: XLEN] = commit_value;
                end else if (busy_q[idx]) begin
                    rd_busy[p]                         = 1'b1;
                    rd_tag[p*ROB_WIDTH_BIT +: ROB_WIDTH_BIT] = tag_q[idx];
                end else begin
                    rd_value[p*XLEN +: XLEN] = regs_q[idx];
                end
            end
        end
    end

    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_rename_regfile.sv
// Randomised and directed bench for rename_regfile against an array-based
// reference model of the architectural/rename state.
module tb_rename_regfile;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in, flush_in;
    logic        rename_en, commit_en;
    logic [4:0]  rename_reg, commit_reg;
    logic [3:0]  rename_tag, commit_tag;
    logic [31:0] commit_value;
    logic [9:0]  rd_reg;
    logic [1:0]  rd_busy;
    logic [63:0] rd_value;
    logic [7:0]  rd_tag;
    logic [5:0]  busy_count;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];
    int unsigned m_cnt;

    rename_regfile #(
        .NUM_REGS(32), .REG_ID_BIT(5), .ROB_WIDTH_BIT(4), .XLEN(32), .NUM_READ(2)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .rename_en(rename_en), .rename_reg(rename_reg), .rename_tag(rename_tag),
        .commit_en(commit_en), .commit_reg(commit_reg), .commit_tag(commit_tag),
        .commit_value(commit_value), .rd_reg(rd_reg), .rd_busy(rd_busy),
        .rd_value(rd_value), .rd_tag(rd_tag), .busy_count(busy_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
        m_cnt = 0;
    endtask

    task automatic apply(input logic rdy, input logic fl, input logic ren, input int rr,
                         input int rt, input logic cen, input int cr, input int ct,
                         input logic [31:0] cv, input int r0, input int r1);
        rdy_in = rdy; flush_in = fl;
        rename_en = ren; rename_reg = 5'(rr); rename_tag = 4'(rt);
        commit_en = cen; commit_reg = 5'(cr); commit_tag = 4'(ct); commit_value = cv;
        rd_reg = {5'(r1), 5'(r0)};
        #1;
    endtask

    // Expected read result from the model state and the current commit inputs.
    task automatic check_reads();
        for (int p = 0; p < 2; p++) begin
            int r;
            logic eb;
            logic [31:0] ev;
            logic [3:0] et;
            r = int'(rd_reg[p*5 +: 5]);
            eb = 1'b0; ev = '0; et = '0;
            if (r != 0) begin
                if (m_busy[r] && commit_en && int'(commit_reg) == r && m_tag[r] == commit_tag)
                    ev = commit_value;
                else if (m_busy[r]) begin
                    eb = 1'b1; et = m_tag[r];
                end else
                    ev = m_regs[r];
            end
            check($sformatf("busy p%0d x%0d", p, r), 32'(rd_busy[p]), 32'(eb));
            check($sformatf("value p%0d x%0d", p, r), rd_value[p*32 +: 32], ev);
            check($sformatf("tag p%0d x%0d", p, r), 32'(rd_tag[p*4 +: 4]), 32'(et));
        end
    endtask

    task automatic tick();
        if (rdy_in) begin
            if (commit_en && commit_reg != 0) begin
                m_regs[commit_reg] = commit_value;
                if (m_tag[commit_reg] == commit_tag) m_busy[commit_reg] = 1'b0;
            end
            if (flush_in) begin
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] = 1'b0; m_tag[i] = '0;
                end
            end else if (rename_en && rename_reg != 0) begin
                m_busy[rename_reg] = 1'b1; m_tag[rename_reg] = rename_tag;
            end
            m_cnt = 0;
            for (int i = 0; i < 32; i++) m_cnt += m_busy[i] ? 1 : 0;
        end
        @(posedge clk_in);
        #1;
        check("busy_count", 32'(busy_count), m_cnt);
    endtask

    task automatic step(input logic rdy, input logic fl, input logic ren, input int rr,
                        input int rt, input logic cen, input int cr, input int ct,
                        input logic [31:0] cv, input int r0, input int r1);
        apply(rdy, fl, ren, rr, rt, cen, cr, ct, cv, r0, r1);
        check_reads();
        tick();
    endtask

    initial begin
        rst_n_in = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk_in);
        #3 rst_n_in = 1'b1;
        check("reset busy_count", 32'(busy_count), 0);

        // Rename then commit with bypass
        step(1, 0, 1, 3, 7, 0, 0, 0, 0, 3, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        check("x3 renamed busy", 32'(rd_busy[0]), 1);
        check("x3 renamed tag", 32'(rd_tag[3:0]), 7);
        check_reads();
        tick();
        apply(1, 0, 0, 0, 0, 1, 3, 7, 32'hDEADBEEF, 3, 3);
        check("x3 bypass busy", 32'(rd_busy[0]), 0);
        check("x3 bypass value", rd_value[31:0], 32'hDEADBEEF);
        check_reads();
        tick();
        check("x3 count after commit", 32'(busy_count), 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        check("x3 regs value", rd_value[31:0], 32'hDEADBEEF);
        check_reads();
        tick();

        // Stale commit
        step(1, 0, 1, 4, 2, 0, 0, 0, 0, 4, 0);
        step(1, 0, 1, 4, 5, 0, 0, 0, 0, 4, 0);
        apply(1, 0, 0, 0, 0, 1, 4, 2, 11, 4, 0);
        check("x4 stale no bypass", 32'(rd_busy[0]), 1);
        check("x4 stale tag", 32'(rd_tag[3:0]), 5);
        check_reads();
        tick();
        step(1, 0, 0, 0, 0, 1, 4, 5, 22, 4, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        check("x4 final value", rd_value[31:0], 22);
        check_reads();
        tick();

        // Same-cycle rename and commit on one register
        step(1, 0, 1, 6, 1, 0, 0, 0, 0, 6, 0);
        step(1, 0, 1, 6, 9, 1, 6, 1, 32'h55, 6, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
        check("x6 rename wins busy", 32'(rd_busy[0]), 1);
        check("x6 rename wins tag", 32'(rd_tag[3:0]), 9);
        check_reads();
        tick();
        step(1, 0, 0, 0, 0, 1, 6, 9, 32'h66, 6, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
        check("x6 final value", rd_value[31:0], 32'h66);
        check_reads();
        tick();

        // x0 and flush
        step(1, 0, 1, 0, 3, 1, 0, 0, 1, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("x0 value", rd_value[31:0], 0);
        check("x0 busy", 32'(rd_busy[0]), 0);
        tick();
        step(1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 3, 3, 0, 0, 0, 0, 0, 0);
        check("count three", 32'(busy_count), 3);
        step(1, 1, 1, 8, 4, 0, 0, 0, 0, 1, 2);
        check("flush count", 32'(busy_count), 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 8, 3);

        // Hold while not ready
        step(1, 0, 1, 10, 4, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            step(0, 0, 1, 11, 6, 1, 10, 4, 32'h77, 10, 11);
        check("rdy low count", 32'(busy_count), 1);

        // Mid-run asynchronous reset
        step(1, 0, 1, 5, 3, 0, 0, 0, 0, 5, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        check("x5 busy before reset", 32'(rd_busy[0]), 1);
        rst_n_in = 1'b0;
        #1;
        model_reset();
        check("reset x5 busy", 32'(rd_busy[0]), 0);
        check("reset x5 value", rd_value[31:0], 0);
        check("reset busy_count", 32'(busy_count), 0);
        #2 rst_n_in = 1'b1;

        // Random traffic on a small register window to force collisions
        for (int k = 0; k < 400; k++) begin
            int rr, cr, ct;
            rr = int'($urandom_range(0, 7));
            cr = int'($urandom_range(0, 7));
            ct = ($urandom_range(0, 1) == 1) ? int'(m_tag[cr]) : int'($urandom_range(0, 15));
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 1)), rr, int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), cr, ct, $urandom,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file with per-register rename state (busy flag plus ROB tag) for the out-of-order core.
- Sits between the decoder and the ROB:
  - The decoder renames destinations and reads NUM_READ source operands per cycle.
  - The ROB commits results.
  - A flush input clears all rename state on mispredict or exception.
- Provides same-cycle commit-to-read bypass.
- x0 is hardwired zero and never renamed.

Parameters:
- NUM_REGS, 32: number of architectural registers (power of two, at least 2).
- REG_ID_BIT, 5: register index width, equal to log2(NUM_REGS).
- ROB_WIDTH_BIT, 4: ROB tag width.
- XLEN, 32: data width.
- NUM_READ, 2: number of source read ports (1..4).

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; low means hold all state.
- flush_in  input  1  clear all rename state.
- rename_en  input  1  rename request from decoder.
- rename_reg  input  REG_ID_BIT  destination register to rename.
- rename_tag  input  ROB_WIDTH_BIT  ROB entry assigned to the destination.
- commit_en  input  1  commit from ROB.
- commit_reg  input  REG_ID_BIT  committed destination register.
- commit_tag  input  ROB_WIDTH_BIT  ROB entry being committed.
- commit_value  input  XLEN  committed result.
- rd_reg  input  NUM_READ*REG_ID_BIT  source indices; port i is slice [i*REG_ID_BIT +: REG_ID_BIT].
- rd_busy  output  NUM_READ  port i operand still pending.
- rd_value  output  NUM_READ*XLEN  port i value; 0 when rd_busy[i].
- rd_tag  output  NUM_READ*ROB_WIDTH_BIT  port i producer tag; 0 when not busy.
- busy_count  output  REG_ID_BIT+1  number of registers currently busy (registered).

Behaviour:
- **Reset** (rst_n_in low, asynchronous):
  - All regs, busy and tag entries cleared.
  - busy_count = 0.
  - Read outputs therefore become busy = 0, value = 0, tag = 0.
- **rdy_in low:** no state changes (rename, commit and flush are all ignored); reads stay combinational.
- **Read, per port, combinational from current state:**
  - r == 0: busy = 0, value = 0, tag = 0.
  - Bypass: busy[r] && commit_en && commit_reg == r && tag[r] == commit_tag → busy = 0, value = commit_value, tag = 0.
  - Otherwise busy[r]: busy = 1, value = 0, tag = tag[r].
  - Otherwise: busy = 0, value = regs[r], tag = 0.
  - A same-cycle rename never affects reads (an instruction's own rd must not alias its sources).
- **Commit** (commit_en, commit_reg != 0):
  - regs[commit_reg] <= commit_value, always, even when a newer tag owns the register.
  - busy cleared only if tag[commit_reg] == commit_tag.
- **Rename** (rename_en, rename_reg != 0): busy <= 1, tag <= rename_tag.
  - The guard uses rename_reg, not commit_reg.
  - Writes to index 0 are dropped for both rename and commit.
- **Simultaneous rename and commit, same register:**
  - Rename wins busy and tag.
  - The value write still happens.
- **Flush** (flush_in, rdy_in high):
  - All busy <= 0, all tags <= 0.
  - regs are updated by a same-cycle commit first, then held.
  - A same-cycle rename is discarded.
  - busy_count <= 0.
- **busy_count:**
  - Registered.
  - Updated each active cycle to the popcount of the next-state busy vector.
  - Equals the number of busy registers one cycle after any update.
- **Latency:**
  - A commit is visible via the bypass in the same cycle and via regs from the next cycle.
  - A rename is visible to reads from the next cycle.
- **Tag reuse:** tags wrap modulo 2^ROB_WIDTH_BIT. Correctness relies on the ROB never reissuing a tag while it is still live.

Test Plan:
- Reset: hold rst_n_in low mid-run with x5 busy → x5 immediately reads busy = 0, value = 0; busy_count = 0.
- Rename then commit:
  - Cycle 1: rename x3 with tag 7.
  - Cycle 2: read port 0 gives busy = 1, tag = 7.
  - Cycle 3: commit x3, tag 7, value 0xDEADBEEF → same cycle port 0 gives busy = 0, value = 0xDEADBEEF.
  - Next cycle: regs holds 0xDEADBEEF; busy_count decrements.
- Stale commit:
  - Rename x4 with tag 2, then rename x4 with tag 5.
  - Commit x4, tag 2, value 11 → x4 stays busy with tag 5, no bypass.
  - After commit tag 5, value 22 → x4 reads 22.
- Same cycle rename x6 tag 9 and commit x6 tag 1 value 0x55 (x6 previously busy with tag 1):
  - Next cycle x6 is busy with tag 9.
  - After commit tag 9, value 0x66 → x6 reads 0x66.
- x0 and flush:
  - Rename x0 and commit x0 with value 1 → x0 reads 0, not busy.
  - Rename x1, x2, x3 → busy_count = 3.
  - flush_in with a simultaneous rename of x8 → all not busy; busy_count = 0.
- rdy_in low for 3 cycles while rename and commit are asserted → no state change; busy_count unchanged.
